// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int SEL_IDX_W  = 4;
  localparam int MAX_SLAVES = 16;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles; terminal flags the last cycle a slave may still answer in.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  // Saturates at the terminal value so an unexpected extra cycle cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + W'(1);
    end
  end

  assign terminal = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request stream to single APB3 transfers, with address-decoded
// one-hot PSEL and a PREADY timeout per transfer.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  apb_state_e           state;
  apb_state_e           next_state;
  logic [SEL_IDX_W-1:0] sel_idx;
  logic [SEL_IDX_W-1:0] req_idx;
  logic                 decode_ok;
  logic                 accept;
  logic                 timeout_hit;

  assign req_idx   = req_addr[SEL_LSB +: SEL_IDX_W];
  assign decode_ok = ({1'b0, req_idx} < (SEL_IDX_W + 1)'(NUM_SLAVES));
  assign accept    = req_valid && req_ready;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state == SETUP),
    .enable  (state == ACCESS),
    .terminal(timeout_hit)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // PREADY is checked before the timeout so a last-cycle answer still completes.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = decode_ok ? SETUP : RESP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      sel_idx   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        PADDR   <= req_addr;
        PWRITE  <= req_write;
        PWDATA  <= req_wdata;
        sel_idx <= req_idx;
        if (!decode_ok) begin
          rsp_rdata <= '0;
          rsp_error <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          rsp_rdata <= PWRITE ? '0 : PRDATA;
          rsp_error <= 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

  // Bus controls come straight from state so an async reset drops them at once.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = (state == SETUP || state == ACCESS) && (sel_idx == SEL_IDX_W'(i));
    end
  end

  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: main instance (16 slaves, timeout 8)
// plus a 4-slave instance used for decode errors.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid4 = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;

  logic        req_ready, rsp_valid, rsp_error, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [15:0] PSEL;

  logic        req_ready4, rsp_valid4, rsp_error4, PENABLE4, PWRITE4;
  logic [31:0] rsp_rdata4, PADDR4, PWDATA4;
  logic [3:0]  PSEL4;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  apb_master_bridge #(
    .NUM_SLAVES(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_master_bridge #(
    .NUM_SLAVES(4)
  ) dut4 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4), .rsp_error(rsp_error4),
    .PADDR(PADDR4), .PSEL(PSEL4), .PENABLE(PENABLE4), .PWRITE(PWRITE4), .PWDATA(PWDATA4),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Presents one request on the main instance and returns just after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic hs;
    logic done;
    done = 1'b0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      hs = req_ready;
      step();
      if (hs) done = 1'b1;
    end
    req_valid = 1'b0;
    checkOutput("accept_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic waitResp(input int limit);
    for (int c = 0; c < limit && !rsp_valid; c++) step();
    checkOutput("resp_seen", {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin : main
    int pen_cycles;
    int n;
    int acc [4];
    logic hs;

    step();
    step();
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("rst_psel", {48'd0, PSEL}, 64'd0);
    checkOutput("rst_penable", {63'd0, PENABLE}, 64'd0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_paddr", {32'd0, PADDR}, 64'd0);
    PRESET = 1'b0;
    step();

    // Zero-wait write to slave 3.
    PREADY = 1'b1;
    applyStimulus(1'b1, 32'h0000_3010, 32'hDEAD_BEEF);
    checkOutput("wr_setup_psel", {48'd0, PSEL}, 64'h0008);
    checkOutput("wr_setup_penable", {63'd0, PENABLE}, 64'd0);
    checkOutput("wr_paddr", {32'd0, PADDR}, 64'h0000_3010);
    checkOutput("wr_pwdata", {32'd0, PWDATA}, 64'hDEAD_BEEF);
    checkOutput("wr_pwrite", {63'd0, PWRITE}, 64'd1);
    checkOutput("wr_req_ready_busy", {63'd0, req_ready}, 64'd0);
    step();
    checkOutput("wr_access_psel", {48'd0, PSEL}, 64'h0008);
    checkOutput("wr_access_penable", {63'd0, PENABLE}, 64'd1);
    checkOutput("wr_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
    step();
    checkOutput("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("wr_rsp_error", {63'd0, rsp_error}, 64'd0);
    checkOutput("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("wr_resp_psel", {48'd0, PSEL}, 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("wr_back_idle", {63'd0, req_ready}, 64'd1);

    // Read from slave 5 with three wait states, then hold off the response.
    PREADY = 1'b0;
    applyStimulus(1'b0, 32'h0000_5000, 32'h0);
    checkOutput("rd_setup_psel", {48'd0, PSEL}, 64'h0020);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("rd_wait_penable", {63'd0, PENABLE}, 64'd1);
      checkOutput("rd_wait_rsp", {63'd0, rsp_valid}, 64'd0);
      checkOutput("rd_paddr_stable", {32'd0, PADDR}, 64'h0000_5000);
    end
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    step();
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    checkOutput("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("rd_rsp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
    checkOutput("rd_rsp_error", {63'd0, rsp_error}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("bp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
      checkOutput("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp_released", {63'd0, rsp_valid}, 64'd0);

    // Decode error on the 4-slave instance: slave index 7.
    req_write  = 1'b0;
    req_addr   = 32'h0000_7000;
    req_valid4 = 1'b1;
    checkOutput("dec_req_ready", {63'd0, req_ready4}, 64'd1);
    step();
    req_valid4 = 1'b0;
    checkOutput("dec_rsp_valid", {63'd0, rsp_valid4}, 64'd1);
    checkOutput("dec_rsp_error", {63'd0, rsp_error4}, 64'd1);
    checkOutput("dec_rsp_rdata", {32'd0, rsp_rdata4}, 64'd0);
    checkOutput("dec_psel", {60'd0, PSEL4}, 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("dec_psel_after", {60'd0, PSEL4}, 64'd0);
    checkOutput("dec_idle", {63'd0, req_ready4}, 64'd1);

    // Timeout with PREADY held low.
    PREADY = 1'b0;
    applyStimulus(1'b0, 32'h0000_1004, 32'h0);
    pen_cycles = 0;
    for (int c = 0; c < 20 && !rsp_valid; c++) begin
      step();
      if (PENABLE) pen_cycles++;
    end
    checkOutput("to_penable_cycles", 64'(pen_cycles), 64'd8);
    checkOutput("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("to_rsp_error", {63'd0, rsp_error}, 64'd1);
    checkOutput("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("to_psel", {48'd0, PSEL}, 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // PREADY arriving on the last timeout cycle completes normally.
    applyStimulus(1'b0, 32'h0000_2008, 32'h0);
    for (int k = 0; k < 8; k++) step();
    checkOutput("lt_still_access", {63'd0, PENABLE}, 64'd1);
    PREADY = 1'b1;
    PRDATA = 32'hCAFE_0008;
    step();
    PREADY = 1'b0;
    checkOutput("lt_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("lt_rsp_error", {63'd0, rsp_error}, 64'd0);
    checkOutput("lt_rsp_rdata", {32'd0, rsp_rdata}, 64'hCAFE_0008);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Four back-to-back writes with the response side always ready.
    PREADY    = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    req_write = 1'b1;
    req_addr  = 32'h0000_1000;
    req_wdata = 32'hA000_0000;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      hs = req_valid && req_ready;
      step();
      if (hs) begin
        acc[n] = cyc;
        checkOutput("b2b_pwdata", {32'd0, PWDATA}, {32'd0, 32'hA000_0000 + 32'(n)});
        n++;
        req_addr  = 32'h0000_1000 * 32'(n + 1);
        req_wdata = 32'hA000_0000 + 32'(n);
        if (n == 4) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_count", 64'(n), 64'd4);
    for (int i = 1; i < 4; i++) checkOutput("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd4);
    for (int k = 0; k < 4; k++) step();
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of ACCESS.
    PREADY = 1'b0;
    applyStimulus(1'b0, 32'h0000_6000, 32'h0);
    step();
    checkOutput("mr_in_access", {63'd0, PENABLE}, 64'd1);
    #2 PRESET = 1'b1;
    #1;
    checkOutput("mr_psel", {48'd0, PSEL}, 64'd0);
    checkOutput("mr_penable", {63'd0, PENABLE}, 64'd0);
    checkOutput("mr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("mr_req_ready", {63'd0, req_ready}, 64'd1);
    #1 PRESET = 1'b0;
    step();
    PREADY = 1'b1;
    applyStimulus(1'b1, 32'h0000_2000, 32'h5555_AAAA);
    checkOutput("mr_next_psel", {48'd0, PSEL}, 64'h0004);
    waitResp(10);
    checkOutput("mr_next_error", {63'd0, rsp_error}, 64'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("mr_next_idle", {63'd0, req_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
